// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - single-entry instruction buffer: tag, data, valid, hit compare
module fetch_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_pc,
  input  logic [WORD_W-1:0] i_load_data,
  input  logic [WORD_W-1:0] i_pc,
  output logic              o_hit,
  output logic [WORD_W-1:0] o_data
);
  logic              r_valid;
  logic [WORD_W-1:0] r_tag;
  logic [WORD_W-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_pc;
      r_data  <= i_load_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_pc);
  assign o_data = r_data;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: buffer hit returns instr, miss fetches over req/ack
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                TIMEOUT  = 16,
  parameter logic [WORD_W-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  input  logic              flush,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              fetch_err
);
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_req_addr;
  logic              r_drop;
  logic [TMO_W-1:0]  r_tmo_cnt;

  logic              w_tag_hit;
  logic              w_hit;
  logic              w_fill;
  logic              w_misaligned;
  logic [WORD_W-1:0] w_buf_data;

  assign w_misaligned = (pc[1:0] != 2'b00);
  // A flush arriving with the ack discards the word just like a pending drop.
  assign w_fill = (r_state == REQ) && mem_ack && !r_drop && !flush;

  fetch_buf u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_fill),
    .i_load_pc   (r_req_addr),
    .i_load_data (mem_rdata),
    .i_pc        (pc),
    .o_hit       (w_tag_hit),
    .o_data      (w_buf_data)
  );

  assign w_hit       = w_tag_hit && (r_state != ERR);
  assign instr       = w_hit ? w_buf_data : NOP_WORD;
  assign instr_valid = w_hit;
  assign stall       = !w_hit;
  assign mem_req     = (r_state == REQ);
  assign mem_addr    = (r_state == REQ) ? r_req_addr : '0;
  assign fetch_err   = (r_state == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_req_addr <= '0;
      r_drop     <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_misaligned) begin
            r_state <= ERR;
          end else if (!w_tag_hit) begin
            r_req_addr <= pc;
            r_tmo_cnt  <= '0;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_drop  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (flush) r_drop <= 1'b1;
            if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              r_tmo_cnt <= TMO_W'(TIMEOUT);
              r_state   <= ERR;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
        end
        ERR:     r_state <= ERR;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        fetch_err;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.TIMEOUT(16), .NOP_WORD(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset(input logic [31:0] p);
    reset = 1'b0; mem_ack = 1'b0; flush = 1'b0; pc = p;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; pc = 32'h0;
    #3;
    tests++;
    if ({mem_req, fetch_err, instr_valid, stall} !== 4'b0001) begin
      fails++; $display("FAIL reset_ctrl: got req/err/valid/stall=%b expected 0001", {mem_req, fetch_err, instr_valid, stall});
    end
    tests++;
    if (mem_addr !== 32'h0 || instr !== 32'h0) begin
      fails++; $display("FAIL reset_data: got addr=%h instr=%h expected 0/0", mem_addr, instr);
    end
    apply_reset(32'h0);
    tests++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL miss_c0: got stall=%b req=%b expected 1/0", stall, mem_req);
    end
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || stall !== 1'b1) begin
      fails++; $display("FAIL miss_c1: got req=%b addr=%h stall=%b expected 1/0/1", mem_req, mem_addr, stall);
    end
    step;
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    #1;
    tests++;
    if (stall !== 1'b1 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL miss_c2: got stall=%b valid=%b expected 1/0", stall, instr_valid);
    end
    step;
    mem_ack = 1'b0;
    #1;
    tests++;
    if (instr !== 32'h2008_0005 || instr_valid !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL miss_c3: got instr=%h valid=%b stall=%b req=%b expected 20080005/1/0/0", instr, instr_valid, stall, mem_req);
    end
  endtask

  task automatic test_hit;
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 2);
      mem_rdata = 32'hBAD0_0000;
      step;
      if (mem_req !== 1'b0 || stall !== 1'b0 || instr !== 32'h2008_0005) bad++;
    end
    mem_ack = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL hit_hold: got %0d bad cycles expected 0", bad);
    end
    pc = 32'h4;
    #1;
    tests++;
    if (stall !== 1'b1 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL hit_newpc: got stall=%b valid=%b expected 1/0", stall, instr_valid);
    end
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      fails++; $display("FAIL hit_miss_req: got req=%b addr=%h expected 1/00000004", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h8C09_0004;
    step;
    mem_ack = 1'b0;
    #1;
    tests++;
    if (instr !== 32'h8C09_0004 || instr_valid !== 1'b1) begin
      fails++; $display("FAIL hit_fill4: got instr=%h valid=%b expected 8c090004/1", instr, instr_valid);
    end
  endtask

  task automatic test_flush;
    int bad = 0;
    pc = 32'h8;
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      fails++; $display("FAIL flush_req: got req=%b addr=%h expected 1/00000008", mem_req, mem_addr);
    end
    flush = 1'b1;
    step;
    flush = 1'b0;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) bad++;
    step;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) bad++;
    step;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF) bad++;
    step;
    mem_ack = 1'b0;
    #1;
    if (instr_valid !== 1'b0 || instr === 32'hDEAD_BEEF || mem_req !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL flush_drop: got %0d bad cycles expected 0", bad);
    end
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL flush_refetch: got req=%b addr=%h valid=%b expected 1/00000008/0", mem_req, mem_addr, instr_valid);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
    step;
    mem_ack = 1'b0;
    #1;
    tests++;
    if (instr !== 32'h0000_0020 || instr_valid !== 1'b1) begin
      fails++; $display("FAIL flush_fill: got instr=%h valid=%b expected 00000020/1", instr, instr_valid);
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    pc = 32'hC;
    for (int i = 0; i < 20; i++) begin
      step;
      if (mem_req === 1'b1) req_cycles++;
    end
    tests++;
    if (req_cycles != 16) begin
      fails++; $display("FAIL tmo_req_cycles: got %0d expected 16", req_cycles);
    end
    tests++;
    if (fetch_err !== 1'b1 || stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++; $display("FAIL tmo_err: got err=%b stall=%b req=%b expected 1/1/0", fetch_err, stall, mem_req);
    end
    pc = 32'h8; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step;
    step;
    mem_ack = 1'b0;
    tests++;
    if (fetch_err !== 1'b1 || stall !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      fails++; $display("FAIL tmo_sticky: got err=%b stall=%b valid=%b instr=%h expected 1/1/0/0", fetch_err, stall, instr_valid, instr);
    end
    apply_reset(32'h8);
    tests++;
    if (fetch_err !== 1'b0) begin
      fails++; $display("FAIL tmo_reset_clear: got err=%b expected 0", fetch_err);
    end
  endtask

  task automatic test_misaligned;
    apply_reset(32'h6);
    tests++;
    if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL mis_c0: got err=%b req=%b expected 0/0", fetch_err, mem_req);
    end
    step;
    tests++;
    if (fetch_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) begin
      fails++; $display("FAIL mis_c1: got err=%b req=%b stall=%b expected 1/0/1", fetch_err, mem_req, stall);
    end
    step;
    tests++;
    if (mem_req !== 1'b0 || fetch_err !== 1'b1) begin
      fails++; $display("FAIL mis_c2: got req=%b err=%b expected 0/1", mem_req, fetch_err);
    end
  endtask

  task automatic test_async_reset;
    apply_reset(32'h10);
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      fails++; $display("FAIL ar_req: got req=%b addr=%h expected 1/00000010", mem_req, mem_addr);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL ar_drop: got req=%b valid=%b err=%b addr=%h expected 0/0/0/0", mem_req, instr_valid, fetch_err, mem_addr);
    end
    pc = 32'h0;
    #1;
    reset = 1'b1;
    step;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      fails++; $display("FAIL ar_refetch: got req=%b addr=%h expected 1/0", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step;
    mem_ack = 1'b0;
    #1;
    tests++;
    if (instr !== 32'h1234_5678 || instr_valid !== 1'b1 || stall !== 1'b0) begin
      fails++; $display("FAIL ar_fill: got instr=%h valid=%b stall=%b expected 12345678/1/0", instr, instr_valid, stall);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_flush();
    test_timeout();
    test_misaligned();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
